usb_rx_data_buffer: RTL and testbench

Receive-side byte FIFO that sits directly downstream of the USB RX receiver. It captures each byte the receiver presents on its `store_rx_packet_data` strobe, holds up to one maximum-size data packet, and hands bytes out in order to the host-side (AHB) interface on request. The receiver's `flush` (start of a new data packet) and the host's `clear` empty it. It reports occupancy, empty and full status to both sides.

---
 rtl/usb_pkg.sv | 12 +
 rtl/usb_rx_data_buffer_if.sv | 36 +++
 rtl/usb_buf_ptr.sv | 17 +
 rtl/usb_rx_data_buffer.sv | 87 ++++++++
 tb/tb_usb_rx_data_buffer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: buffer depth, byte type and the per-cycle FIFO operation bundle.
package usb_pkg;
  localparam int USB_BUF_DEPTH = 64;
  localparam int USB_OCC_W     = $clog2(USB_BUF_DEPTH + 1);

  typedef logic [7:0] usb_byte_t;

  typedef struct packed {
    logic push;
    logic pop;
  } usb_buf_op_t;
endpackage

// File: rtl/usb_rx_data_buffer_if.sv
// Bus between the RX receiver / host side (master) and the receive byte FIFO (slave).
// rx_overflow is present only when USB_RXBUF_OVERFLOW_EN is defined.
interface usb_rx_data_buffer_if #(
  parameter int DEPTH = usb_pkg::USB_BUF_DEPTH
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             store_rx_packet_data;
  logic [7:0]       rx_packet_data;
  logic             flush;
  logic             clear;
  logic             get_rx_data;
  logic [7:0]       rx_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             buffer_empty;
  logic             buffer_full;
`ifdef USB_RXBUF_OVERFLOW_EN
  logic             rx_overflow;
`endif

  modport master (
    output store_rx_packet_data, rx_packet_data, flush, clear, get_rx_data,
`ifdef USB_RXBUF_OVERFLOW_EN
    input  rx_overflow,
`endif
    input  rx_data, buffer_occupancy, buffer_empty, buffer_full
  );

  modport slave (
    input  store_rx_packet_data, rx_packet_data, flush, clear, get_rx_data,
`ifdef USB_RXBUF_OVERFLOW_EN
    output rx_overflow,
`endif
    output rx_data, buffer_occupancy, buffer_empty, buffer_full
  );
endinterface

// File: rtl/usb_buf_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous zero.
module usb_buf_ptr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         zero,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  // Natural binary wrap from 2**W-1 back to 0; zero beats inc.
  always_ff @(posedge clk) begin
    if (!n_rst)    ptr <= '0;
    else if (zero) ptr <= '0;
    else if (inc)  ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/usb_rx_data_buffer.sv
// Receive-side byte FIFO between the USB RX receiver and the host interface.
// Optional sticky rx_overflow flag enabled by defining USB_RXBUF_OVERFLOW_EN.
module usb_rx_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_BUF_DEPTH
) (
  input logic clk,
  input logic n_rst,
  usb_rx_data_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("usb_rx_data_buffer: DEPTH must be a power of two in 4..256");
  end

  usb_byte_t        mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ;
  logic             empty;
  logic             full;
  logic             zero;
  usb_buf_op_t      op;

  assign empty = (occ == '0);
  assign full  = (occ == FULL_CNT);
  assign zero  = bus.flush | bus.clear;

  // A push into a full buffer is only allowed when a pop frees the slot this cycle.
  assign op.pop  = bus.get_rx_data & ~empty;
  assign op.push = bus.store_rx_packet_data & (~full | op.pop);

  usb_buf_ptr #(.W(PTR_W)) u_wptr (
    .clk   (clk),
    .n_rst (n_rst),
    .zero  (zero),
    .inc   (op.push),
    .ptr   (wptr)
  );

  usb_buf_ptr #(.W(PTR_W)) u_rptr (
    .clk   (clk),
    .n_rst (n_rst),
    .zero  (zero),
    .inc   (op.pop),
    .ptr   (rptr)
  );

  always_ff @(posedge clk) begin
    if (n_rst && !zero && op.push) mem[wptr] <= bus.rx_packet_data;
  end

  always_ff @(posedge clk) begin
    if (!n_rst)    occ <= '0;
    else if (zero) occ <= '0;
    else begin
      case ({op.push, op.pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef USB_RXBUF_OVERFLOW_EN
  logic ovf;

  // Sticky until emptied; an empty request wins over a same-cycle violation.
  always_ff @(posedge clk) begin
    if (!n_rst)    ovf <= 1'b0;
    else if (zero) ovf <= 1'b0;
    else if ((bus.store_rx_packet_data & ~op.push) | (bus.get_rx_data & empty))
      ovf <= 1'b1;
  end

  assign bus.rx_overflow = ovf;
`endif

  assign bus.rx_data          = empty ? 8'h00 : mem[rptr];
  assign bus.buffer_occupancy = occ;
  assign bus.buffer_empty     = empty;
  assign bus.buffer_full      = full;
endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Self-checking bench for usb_rx_data_buffer: vector table, reference FIFO model and pop scoreboard.
module tb_usb_rx_data_buffer;
  import usb_pkg::*;

  localparam int DEPTH = USB_BUF_DEPTH;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_data_buffer_if #(.DEPTH(DEPTH)) bus();

  usb_rx_data_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned model[$];
  byte unsigned sb[$];
`ifdef USB_RXBUF_OVERFLOW_EN
  logic m_ovf = 1'b0;
`endif

  typedef struct {
    logic       st;
    logic [7:0] d;
    logic       gt;
    logic       fl;
    logic       cl;
    int         occ;
    logic [7:0] head;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = model.size();
    check({tag, " occupancy"}, 32'(bus.buffer_occupancy), 32'(n));
    check({tag, " empty"}, 32'(bus.buffer_empty), 32'(n == 0));
    check({tag, " full"}, 32'(bus.buffer_full), 32'(n == DEPTH));
    check({tag, " rx_data"}, 32'(bus.rx_data), (n == 0) ? 32'h0 : 32'(model[0]));
`ifdef USB_RXBUF_OVERFLOW_EN
    check({tag, " rx_overflow"}, 32'(bus.rx_overflow), 32'(m_ovf));
`endif
  endtask

  // One clock: drive, verify the head byte being popped, advance the model, verify state.
  task automatic cyc(input logic st, input logic [7:0] d, input logic gt,
                     input logic fl, input logic cl, input string tag);
    logic zero, pop_ok, push_ok;
    bus.store_rx_packet_data = st;
    bus.rx_packet_data       = d;
    bus.get_rx_data          = gt;
    bus.flush                = fl;
    bus.clear                = cl;
    zero    = fl | cl;
    pop_ok  = gt && model.size() > 0;
    push_ok = st && (model.size() < DEPTH || pop_ok);
    if (pop_ok && !zero) sb.push_back(model[0]);
    #1;
    if (pop_ok && !zero) check({tag, " pop_data"}, 32'(bus.rx_data), 32'(sb.pop_front()));
    if (zero) begin
      model.delete();
`ifdef USB_RXBUF_OVERFLOW_EN
      m_ovf = 1'b0;
`endif
    end else begin
`ifdef USB_RXBUF_OVERFLOW_EN
      if ((gt && !pop_ok) || (st && !push_ok)) m_ovf = 1'b1;
`endif
      if (pop_ok)  void'(model.pop_front());
      if (push_ok) model.push_back(d);
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle();
    bus.store_rx_packet_data = 1'b0;
    bus.rx_packet_data       = 8'h00;
    bus.get_rx_data          = 1'b0;
    bus.flush                = 1'b0;
    bus.clear                = 1'b0;
  endtask

  initial begin
    idle();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset occupancy", 32'(bus.buffer_occupancy), 32'd0);
    check("reset empty", 32'(bus.buffer_empty), 32'd1);
    check("reset full", 32'(bus.buffer_full), 32'd0);
    check("reset rx_data", 32'(bus.rx_data), 32'h00);
`ifdef USB_RXBUF_OVERFLOW_EN
    check("reset rx_overflow", 32'(bus.rx_overflow), 32'd0);
`endif
    n_rst = 1'b1;

    // Basic push/pop plus empty-side corners, with hand-derived expectations.
    vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 8'hA5};
    vt[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 2, 8'hA5};
    vt[2] = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 3, 8'hA5};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 8'h3C};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 8'h7E};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00};
    vt[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00};
    vt[8] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1, 8'h11};
    vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00};
    for (int i = 0; i < 10; i++) begin
      cyc(vt[i].st, vt[i].d, vt[i].gt, vt[i].fl, vt[i].cl, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl_occ", i), 32'(bus.buffer_occupancy), 32'(vt[i].occ));
      check($sformatf("vec%0d tbl_head", i), 32'(bus.rx_data), 32'(vt[i].head));
    end
    idle();

    // Fill to capacity, drop one, drain in order.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
    check("fill full", 32'(bus.buffer_full), 32'd1);
    check("fill occupancy", 32'(bus.buffer_occupancy), 32'(DEPTH));
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "drop");
    check("drop occupancy", 32'(bus.buffer_occupancy), 32'(DEPTH));
`ifdef USB_RXBUF_OVERFLOW_EN
    check("drop overflow", 32'(bus.rx_overflow), 32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      check("drain head", 32'(bus.rx_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
    end
    check("drain empty", 32'(bus.buffer_empty), 32'd1);

    // Pre-offset pointers by 10, refill, push+pop while full, drain across the wrap.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr");
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, "off_push");
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "off_pop");
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i + 100), 1'b0, 1'b0, 1'b0, "wfill");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'hC8 + i), 1'b1, 1'b0, 1'b0, "full_pp");
      check("full_pp occupancy", 32'(bus.buffer_occupancy), 32'(DEPTH));
    end
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "wdrain");
    check("wdrain empty", 32'(bus.buffer_empty), 32'd1);

    // Flush collides with push and pop while 5 bytes are held.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, "fc_push");
    cyc(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, "flush_coll");
    check("flush_coll occupancy", 32'(bus.buffer_occupancy), 32'd0);
    check("flush_coll empty", 32'(bus.buffer_empty), 32'd1);
    check("flush_coll rx_data", 32'(bus.rx_data), 32'h00);

    // Clear while idle with 3 bytes, then reuse.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, "cl_push");
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clear_idle");
    check("clear occupancy", 32'(bus.buffer_occupancy), 32'd0);
    cyc(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, "after_clear");
    check("after_clear rx_data", 32'(bus.rx_data), 32'h42);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "after_clear_pop");

    // Reset mid-fill, with a push pending on the reset edge.
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0, "mid");
    bus.store_rx_packet_data = 1'b1;
    bus.rx_packet_data       = 8'hEE;
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    model.delete();
`ifdef USB_RXBUF_OVERFLOW_EN
    m_ovf = 1'b0;
`endif
    check("midrst occupancy", 32'(bus.buffer_occupancy), 32'd0);
    check("midrst empty", 32'(bus.buffer_empty), 32'd1);
    check("midrst full", 32'(bus.buffer_full), 32'd0);
    check("midrst rx_data", 32'(bus.rx_data), 32'h00);
    idle();
    n_rst = 1'b1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, "post_rst");
    check("post_rst rx_data", 32'(bus.rx_data), 32'h77);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
